// File: rtl/cic3_row_readout_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : cic3_row_readout_sched_if
//  Description : Valid/ready word stream from the CIC3 row readout scheduler
//                to downstream packing/serialisation logic.
//                master = scheduler (drives words), slave = consumer.
//                With CIC3_ROW_FRAME_TAG_EN defined, an 8-bit frame tag
//                (out_frame) travels with every word.
//  Signals     : out_valid  word valid
//                out_ready  consumer accepts the word
//                out_chan   channel index of the word
//                out_data   captured filter bit of that channel
//                out_first  first word of a frame
//                out_frame  frame tag (optional)
//  Revision    : 1.0  initial release
// ============================================================================
interface cic3_row_readout_sched_if #(
    parameter int CHAN_W = 5
);
    logic              out_valid;
    logic              out_ready;
    logic [CHAN_W-1:0] out_chan;
    logic              out_data;
    logic              out_first;
`ifdef CIC3_ROW_FRAME_TAG_EN
    logic [7:0]        out_frame;

    modport master (
        output out_valid, out_chan, out_data, out_first, out_frame,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_chan, out_data, out_first, out_frame,
        output out_ready
    );
`else
    modport master (
        output out_valid, out_chan, out_data, out_first,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_chan, out_data, out_first,
        output out_ready
    );
`endif
endinterface
`default_nettype wire

// File: rtl/cic3_row_readout_sched.sv
`default_nettype none
// ============================================================================
//  Module      : cic3_row_readout_sched
//  Description : Readout scheduler for a 2x12 row of CIC3 decimation filters.
//                A frame divider produces one strobe every DECIM_RATIO clocks;
//                on each accepted strobe the masked filter outputs are
//                captured into a shadow register and drained one channel per
//                handshake in ascending channel order. A strobe that arrives
//                while a frame is still draining is dropped and flagged via
//                the sticky overrun output.
//  Macro       : CIC3_ROW_FRAME_TAG_EN - adds an 8-bit frame sequence tag
//                (out_if.out_frame) that counts every strobe, dropped or not.
//  Ports       : clk            sole clock
//                reset          synchronous active-high reset
//                enable         run the frame divider
//                chan_mask      per-channel readout enable (sampled at capture)
//                filt_out       filter row outputs, bit j = channel j
//                frame_strobe   one-cycle frame pulse (combinational)
//                overrun        sticky frame-dropped flag
//                clear_overrun  clears overrun (a same-cycle drop wins)
//                out_if         word stream (master side)
//  Revision    : 1.0  initial release
// ============================================================================
module cic3_row_readout_sched #(
    parameter int NUM_CHANNELS = 24,
    parameter int DECIM_RATIO  = 16,
    parameter int CHAN_W       = 5,
    parameter int DIV_W        = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [NUM_CHANNELS-1:0] chan_mask,
    input  logic [NUM_CHANNELS-1:0] filt_out,
    output logic                    frame_strobe,
    output logic                    overrun,
    input  logic                    clear_overrun,
    cic3_row_readout_sched_if.master out_if
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DECIM_RATIO - 1);

    logic [DIV_W-1:0]        div_cnt_q,    div_cnt_d;
    logic [0:0]              state_q,      state_d;
    logic [NUM_CHANNELS-1:0] shadow_q,     shadow_d;
    logic [NUM_CHANNELS-1:0] pending_q,    pending_d;
    logic                    first_flag_q, first_flag_d;
    logic                    overrun_q,    overrun_d;

    logic [CHAN_W-1:0]       sel_idx;
    logic [NUM_CHANNELS-1:0] sel_onehot;
    logic                    scanning;
    logic                    handshake;
    logic                    last_word;
    logic                    capture;
    logic                    drop;

    // ------------------------------------------------------------------
    // Lowest-set-bit select over the pending vector
    // ------------------------------------------------------------------
    always_comb begin
        sel_idx = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_idx = CHAN_W'(i);
            end
        end
    end

    // Two's-complement trick isolates the lowest set bit.
    assign sel_onehot = pending_q & (~pending_q + NUM_CHANNELS'(1));

    // ------------------------------------------------------------------
    // Control terms
    // ------------------------------------------------------------------
    assign frame_strobe = enable && (div_cnt_q == DIV_LAST);
    assign scanning     = (state_q == ST_SCAN);
    assign handshake    = scanning && out_if.out_ready;
    // The word being accepted is the last one when nothing else remains.
    assign last_word    = handshake && ((pending_q & ~sel_onehot) == '0);
    // A frame can be accepted when idle, or when the current frame finishes
    // in this very cycle (back-to-back frames without a bubble).
    assign capture      = frame_strobe && (!scanning || last_word);
    assign drop         = frame_strobe && scanning && !last_word;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        div_cnt_d    = div_cnt_q;
        state_d      = state_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        first_flag_d = first_flag_q;
        overrun_d    = overrun_q;

        if (!enable) begin
            div_cnt_d = '0;
        end else if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        if (handshake) begin
            pending_d    = pending_q & ~sel_onehot;
            first_flag_d = 1'b0;
            if (last_word) begin
                state_d = ST_IDLE;
            end
        end

        // Capture overrides the drain update: the old frame is finished.
        if (capture) begin
            shadow_d     = filt_out;
            pending_d    = chan_mask;
            first_flag_d = 1'b1;
            state_d      = (chan_mask != '0) ? ST_SCAN : ST_IDLE;
        end

        // Set has priority over clear.
        if (drop) begin
            overrun_d = 1'b1;
        end else if (clear_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q    <= '0;
            state_q      <= ST_IDLE;
            shadow_q     <= '0;
            pending_q    <= '0;
            first_flag_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            first_flag_q <= first_flag_d;
            overrun_q    <= overrun_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: data and first are gated so the stream is quiet when idle.
    // ------------------------------------------------------------------
    assign out_if.out_valid = scanning;
    assign out_if.out_chan  = sel_idx;
    assign out_if.out_data  = scanning && ((shadow_q & sel_onehot) != '0);
    assign out_if.out_first = scanning && first_flag_q;
    assign overrun          = overrun_q;

`ifdef CIC3_ROW_FRAME_TAG_EN
    // ------------------------------------------------------------------
    // Frame sequence tag: counts every strobe; a captured frame keeps the
    // count value seen at its strobe, so the first frame carries tag 0.
    // ------------------------------------------------------------------
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic [7:0] frame_tag_q, frame_tag_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        frame_tag_d = frame_tag_q;
        if (frame_strobe) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
        if (capture) begin
            frame_tag_d = frame_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= '0;
            frame_tag_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            frame_tag_q <= frame_tag_d;
        end
    end

    assign out_if.out_frame = frame_tag_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cic3_row_readout_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cic3_row_readout_sched
//  Description : Directed self-checking bench for cic3_row_readout_sched.
//                Three instances (DECIM_RATIO 16, 64, 4) share the stimulus;
//                each scenario checks the instance it targets. Inputs change
//                on the falling edge, outputs are sampled there as well.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cic3_row_readout_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        clear_overrun;
    logic        ready;
    logic [23:0] chan_mask;
    logic [23:0] filt_out;
    logic        fs16, fs64, fs4;
    logic        ov16, ov64, ov4;

    always #5 clk = ~clk;

    cic3_row_readout_sched_if #(.CHAN_W(5)) if16 ();
    cic3_row_readout_sched_if #(.CHAN_W(5)) if64 ();
    cic3_row_readout_sched_if #(.CHAN_W(5)) if4  ();

    assign if16.out_ready = ready;
    assign if64.out_ready = ready;
    assign if4.out_ready  = ready;

    cic3_row_readout_sched #(.NUM_CHANNELS(24), .DECIM_RATIO(16), .CHAN_W(5), .DIV_W(16)) u16 (
        .clk(clk), .reset(reset), .enable(enable), .chan_mask(chan_mask), .filt_out(filt_out),
        .frame_strobe(fs16), .overrun(ov16), .clear_overrun(clear_overrun), .out_if(if16));
    cic3_row_readout_sched #(.NUM_CHANNELS(24), .DECIM_RATIO(64), .CHAN_W(5), .DIV_W(16)) u64 (
        .clk(clk), .reset(reset), .enable(enable), .chan_mask(chan_mask), .filt_out(filt_out),
        .frame_strobe(fs64), .overrun(ov64), .clear_overrun(clear_overrun), .out_if(if64));
    cic3_row_readout_sched #(.NUM_CHANNELS(24), .DECIM_RATIO(4), .CHAN_W(5), .DIV_W(16)) u4 (
        .clk(clk), .reset(reset), .enable(enable), .chan_mask(chan_mask), .filt_out(filt_out),
        .frame_strobe(fs4), .overrun(ov4), .clear_overrun(clear_overrun), .out_if(if4));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic bit_of(input logic [23:0] v, input int j);
        return v[j[4:0]];
    endfunction

    // Leaves the bench on a falling edge with reset just released; all
    // dividers sit at 0 on this edge (cycle k = 0 of a scenario).
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; enable = 1'b0; ready = 1'b1; clear_overrun = 1'b0;
        chan_mask = '0; filt_out = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [23:0] f;
        logic [23:0] sparse_f;
        int          j;
        int          words;
        int          sparse_idx [3] = '{0, 8, 23};

        // ---------------- reset state ----------------
        do_reset();
        check_value("rst_valid", 32'(if16.out_valid), 32'd0);
        check_value("rst_chan",  32'(if16.out_chan),  32'd0);
        check_value("rst_data",  32'(if16.out_data),  32'd0);
        check_value("rst_first", 32'(if16.out_first), 32'd0);
        check_value("rst_ovr",   32'(ov16),           32'd0);
        check_value("rst_strobe",32'(fs16),           32'd0);

        // ---------------- full mask, ready high (R=16) ----------------
        // Strobe 15 captured; strobe 31 lands mid-drain and is dropped.
        f = 24'hA5A5A5;
        enable = 1'b1; chan_mask = 24'hFFFFFF; filt_out = f; ready = 1'b1;
        for (int k = 0; k <= 42; k++) begin
            check_value("full_strobe", 32'(fs16), 32'(k == 15 || k == 31));
            if (k >= 16 && k <= 39) begin
                j = k - 16;
                check_value("full_valid", 32'(if16.out_valid), 32'd1);
                check_value("full_chan",  32'(if16.out_chan),  32'(j));
                check_value("full_data",  32'(if16.out_data),  32'(bit_of(f, j)));
                check_value("full_first", 32'(if16.out_first), 32'(j == 0));
            end else begin
                check_value("full_idle",  32'(if16.out_valid), 32'd0);
            end
            if (k == 31) check_value("full_ovr_pre",   32'(ov16), 32'd0);
            if (k == 32) check_value("full_ovr_set",   32'(ov16), 32'd1);
            if (k == 42) check_value("full_ovr_clear", 32'(ov16), 32'd0);
            clear_overrun = (k == 41);
            @(negedge clk);
        end
        clear_overrun = 1'b0;

        // ---------------- sparse mask (R=16) ----------------
        do_reset();
        sparse_f = 24'h7FFF00;
        enable = 1'b1; chan_mask = 24'h800101; filt_out = sparse_f; ready = 1'b1;
        for (int k = 0; k <= 36; k++) begin
            if ((k >= 16 && k <= 18) || (k >= 32 && k <= 34)) begin
                j = sparse_idx[(k - 16) % 16];
                check_value("sparse_valid", 32'(if16.out_valid), 32'd1);
                check_value("sparse_chan",  32'(if16.out_chan),  32'(j));
                check_value("sparse_data",  32'(if16.out_data),  32'(bit_of(sparse_f, j)));
                check_value("sparse_first", 32'(if16.out_first), 32'(j == 0));
            end else begin
                check_value("sparse_idle",  32'(if16.out_valid), 32'd0);
            end
            @(negedge clk);
        end

        // ---------------- back-pressure stall (R=64) ----------------
        do_reset();
        f = 24'h5A3C96;
        enable = 1'b1; chan_mask = 24'hFFFFFF; filt_out = f; ready = 1'b1;
        j = 0;
        for (int k = 0; k <= 100; k++) begin
            if (k == 63) check_value("stall_strobe", 32'(fs64), 32'd1);
            if (k >= 64 && j < 24) begin
                check_value("stall_valid", 32'(if64.out_valid), 32'd1);
                check_value("stall_chan",  32'(if64.out_chan),  32'(j));
                check_value("stall_data",  32'(if64.out_data),  32'(bit_of(f, j)));
                check_value("stall_first", 32'(if64.out_first), 32'(j == 0));
            end else begin
                check_value("stall_idle",  32'(if64.out_valid), 32'd0);
            end
            ready = !(k >= 70 && k <= 74);
            if (k >= 64 && j < 24 && ready) j++;
            @(negedge clk);
        end
        check_value("stall_words", 32'(j),    32'd24);
        check_value("stall_ovr",   32'(ov64), 32'd0);
        ready = 1'b1;

        // ---------------- overrun, ready 1 in 4 (R=16) ----------------
        do_reset();
        f = 24'hC35A0F;
        enable = 1'b1; chan_mask = 24'hFFFFFF; filt_out = f;
        j = 0;
        for (int k = 0; k <= 109; k++) begin
            if (k >= 16 && j < 24) begin
                check_value("ovr_valid", 32'(if16.out_valid), 32'd1);
                check_value("ovr_chan",  32'(if16.out_chan),  32'(j));
                check_value("ovr_data",  32'(if16.out_data),  32'(bit_of(f, j)));
            end else begin
                check_value("ovr_idle",  32'(if16.out_valid), 32'd0);
            end
            if (k == 31) check_value("ovr_pre",        32'(ov16), 32'd0);
            if (k == 32) check_value("ovr_set",        32'(ov16), 32'd1);
            if (k == 34) check_value("ovr_clear",      32'(ov16), 32'd0);
            if (k == 48) check_value("ovr_set_wins",   32'(ov16), 32'd1);
            // Different data for the frames that must be dropped.
            if (k == 20) filt_out = ~f;
            clear_overrun = (k == 33) || (k == 47);
            ready = (k % 4 == 0);
            if (k >= 16 && j < 24 && ready) j++;
            @(negedge clk);
        end
        check_value("ovr_words", 32'(j), 32'd24);
        clear_overrun = 1'b0; ready = 1'b1;

        // ---------------- back-to-back frames (R=4) ----------------
        // Mask 3 leaves a gap each frame; mask F (from strobe 23) makes the
        // last handshake coincide with every strobe.
        do_reset();
        enable = 1'b1; chan_mask = 24'h000003; filt_out = 24'h000002; ready = 1'b1;
        for (int k = 0; k <= 44; k++) begin
            check_value("b2b_strobe", 32'(fs4), 32'(k % 4 == 3));
            if (k >= 24 || (k >= 4 && k % 4 < 2)) begin
                check_value("b2b_valid", 32'(if4.out_valid), 32'd1);
                check_value("b2b_chan",  32'(if4.out_chan),  32'(k % 4));
                check_value("b2b_data",  32'(if4.out_data),  32'(k % 4 == 1));
                check_value("b2b_first", 32'(if4.out_first), 32'(k % 4 == 0));
            end else begin
                check_value("b2b_idle",  32'(if4.out_valid), 32'd0);
            end
            if (k == 21) chan_mask = 24'h00000F;
            @(negedge clk);
        end
        check_value("b2b_ovr", 32'(ov4), 32'd0);

        // ---------------- reset mid-SCAN (R=16) ----------------
        do_reset();
        enable = 1'b1; chan_mask = 24'hFFFFFF; filt_out = 24'hA5A5A5; ready = 1'b1;
        for (int k = 0; k <= 37; k++) begin
            if (k == 20) begin
                check_value("rscan_pre_valid", 32'(if16.out_valid), 32'd1);
                check_value("rscan_pre_chan",  32'(if16.out_chan),  32'd4);
            end
            if (k >= 21 && k <= 36) begin
                check_value("rscan_valid", 32'(if16.out_valid), 32'd0);
                check_value("rscan_chan",  32'(if16.out_chan),  32'd0);
            end
            if (k == 36) check_value("rscan_strobe", 32'(fs16), 32'd1);
            if (k == 37) check_value("rscan_restart", 32'(if16.out_valid), 32'd1);
            reset = (k == 20);
            @(negedge clk);
        end
        reset = 1'b0;

        // ---------------- enable dropped mid-frame (R=16) ----------------
        do_reset();
        enable = 1'b1; chan_mask = 24'hFFFFFF; filt_out = 24'hA5A5A5; ready = 1'b1;
        words = 0;
        for (int k = 0; k <= 80; k++) begin
            check_value("en_strobe", 32'(fs16), 32'(k == 15));
            if (k >= 40) check_value("en_idle", 32'(if16.out_valid), 32'd0);
            if (if16.out_valid && ready) words++;
            if (k == 20) enable = 1'b0;
            @(negedge clk);
        end
        check_value("en_words", 32'(words), 32'd24);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
